// File: rtl/psk_rx_demod_if.sv
//==============================================================================
// psk_rx_demod_if : I/Q sample input and bit-decision output bundle (rev 1.0)
//==============================================================================
`default_nettype none

interface psk_rx_demod_if #(
  parameter int DW = 12
);
  logic signed [DW-1:0] ADC_I;
  logic signed [DW-1:0] ADC_Q;
  logic                 is_bpsk;
  logic                 BPSK;
  logic [1:0]           QPSK;
  logic                 vld;

  modport master (
    output ADC_I, ADC_Q, is_bpsk,
    input  BPSK, QPSK, vld
  );

  modport slave (
    input  ADC_I, ADC_Q, is_bpsk,
    output BPSK, QPSK, vld
  );
endinterface

`default_nettype wire

// File: rtl/psk_rx_demod.sv
//==============================================================================
// psk_rx_demod : BPSK/QPSK integrate-and-dump receiver, zero-crossing timing (rev 1.0)
//==============================================================================
`default_nettype none

module psk_rx_demod #(
  parameter int DW  = 12,
  parameter int SPS = 32
) (
  input  wire logic       clk_16M384,
  input  wire logic       rst_n_16M384,
  psk_rx_demod_if.slave   bus
);
  localparam int CW = $clog2(SPS);
  localparam int AW = DW + CW;
  localparam logic [CW-1:0] CNT_LAST = CW'(SPS - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(SPS / 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [AW-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic                 prev_i_q, prev_q_q;
  logic                 locked_q, locked_d;
  logic                 bpsk_q, bpsk_d;
  logic [1:0]           qpsk_q, qpsk_d;
  logic                 vld_q, vld_d;

  logic                 sign_i, sign_q, trans;
  logic signed [AW-1:0] ext_i, ext_q, sum_i, sum_q;

  assign sign_i = bus.ADC_I[DW-1];
  assign sign_q = bus.ADC_Q[DW-1];
  assign ext_i  = {{CW{bus.ADC_I[DW-1]}}, bus.ADC_I};
  assign ext_q  = {{CW{bus.ADC_Q[DW-1]}}, bus.ADC_Q};
  assign sum_i  = acc_i_q + ext_i;
  assign sum_q  = acc_q_q + ext_q;
  // In BPSK mode Q carries no symbol information, so only I crossings retime.
  assign trans  = (sign_i != prev_i_q) | (~bus.is_bpsk & (sign_q != prev_q_q));

  always_comb begin
    cnt_d    = cnt_q;
    acc_i_d  = acc_i_q;
    acc_q_d  = acc_q_q;
    locked_d = locked_q;
    bpsk_d   = bpsk_q;
    qpsk_d   = qpsk_q;
    vld_d    = 1'b0;
    if (trans && !locked_q) begin
      locked_d = 1'b1;
      cnt_d    = CNT_ONE;
      acc_i_d  = ext_i;
      acc_q_d  = ext_q;
    end else if (trans && cnt_q >= CNT_HALF) begin
      // Symbol ended early: the current sample already belongs to the next one.
      bpsk_d  = ~acc_i_q[AW-1];
      qpsk_d  = {~acc_i_q[AW-1], ~acc_q_q[AW-1]};
      vld_d   = 1'b1;
      cnt_d   = CNT_ONE;
      acc_i_d = ext_i;
      acc_q_d = ext_q;
    end else if (trans && cnt_q != '0) begin
      cnt_d   = CNT_ONE;
      acc_i_d = ext_i;
      acc_q_d = ext_q;
    end else if (locked_q && cnt_q == CNT_LAST) begin
      bpsk_d  = ~sum_i[AW-1];
      qpsk_d  = {~sum_i[AW-1], ~sum_q[AW-1]};
      vld_d   = 1'b1;
      cnt_d   = '0;
      acc_i_d = '0;
      acc_q_d = '0;
    end else if (locked_q) begin
      cnt_d   = cnt_q + CNT_ONE;
      acc_i_d = sum_i;
      acc_q_d = sum_q;
    end
  end

  always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
    if (!rst_n_16M384) begin
      cnt_q    <= '0;
      acc_i_q  <= '0;
      acc_q_q  <= '0;
      prev_i_q <= 1'b0;
      prev_q_q <= 1'b0;
      locked_q <= 1'b0;
      bpsk_q   <= 1'b0;
      qpsk_q   <= 2'b00;
      vld_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_i_q  <= acc_i_d;
      acc_q_q  <= acc_q_d;
      prev_i_q <= sign_i;
      prev_q_q <= sign_q;
      locked_q <= locked_d;
      bpsk_q   <= bpsk_d;
      qpsk_q   <= qpsk_d;
      vld_q    <= vld_d;
    end
  end

  assign bus.BPSK = bpsk_q;
  assign bus.QPSK = qpsk_q;
  assign bus.vld  = vld_q;
endmodule

`default_nettype wire

// File: tb/tb_psk_rx_demod.sv
//==============================================================================
// tb_psk_rx_demod : scoreboard bench for psk_rx_demod with a sample-level model (rev 1.0)
//==============================================================================
`default_nettype none

module tb_psk_rx_demod;
  localparam int DW  = 12;
  localparam int SPS = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #30 clk = ~clk;

  psk_rx_demod_if #(.DW(DW)) ifc();

  psk_rx_demod #(.DW(DW), .SPS(SPS)) dut (
    .clk_16M384  (clk),
    .rst_n_16M384(rst_n),
    .bus         (ifc.slave)
  );

  typedef struct {
    int       cyc;
    bit       b;
    bit [1:0] dq;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference receiver state, plain integers
  int m_cnt, m_acc_i, m_acc_q, m_locked;
  bit m_prev_i, m_prev_q;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_acc_i = 0; m_acc_q = 0; m_locked = 0;
    m_prev_i = 0; m_prev_q = 0;
  endtask

  task automatic expect_dump(input int vi, input int vq);
    exp_t e;
    e.cyc = cyc + 1;
    e.b   = (vi >= 0);
    e.dq  = {(vi >= 0), (vq >= 0)};
    sb.push_back(e);
  endtask

  task automatic model_step(input int i, input int q, input bit bpsk);
    bit si, sq, t;
    si = (i < 0);
    sq = (q < 0);
    t  = (si != m_prev_i) || (!bpsk && (sq != m_prev_q));
    if (t && m_locked == 0) begin
      m_locked = 1; m_cnt = 1; m_acc_i = i; m_acc_q = q;
    end else if (t && m_cnt >= SPS/2) begin
      expect_dump(m_acc_i, m_acc_q);
      m_cnt = 1; m_acc_i = i; m_acc_q = q;
    end else if (t && m_cnt >= 1) begin
      m_cnt = 1; m_acc_i = i; m_acc_q = q;
    end else if (m_locked != 0 && m_cnt == SPS-1) begin
      expect_dump(m_acc_i + i, m_acc_q + q);
      m_cnt = 0; m_acc_i = 0; m_acc_q = 0;
    end else if (m_locked != 0) begin
      m_cnt++; m_acc_i += i; m_acc_q += q;
    end
    m_prev_i = si;
    m_prev_q = sq;
  endtask

  task automatic drive(input int i, input int q, input bit bpsk);
    @(negedge clk);
    rst_n       = 1'b1;
    ifc.ADC_I   = i[DW-1:0];
    ifc.ADC_Q   = q[DW-1:0];
    ifc.is_bpsk = bpsk;
    model_step(i, q, bpsk);
  endtask

  task automatic apply_reset(input int n);
    int r;
    model_reset();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst_n       = 1'b0;
      r           = int'($urandom_range(0, 4095));
      ifc.ADC_I   = r[DW-1:0];
      r           = int'($urandom_range(0, 4095));
      ifc.ADC_Q   = r[DW-1:0];
      ifc.is_bpsk = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic sym(input int i, input int q, input int len, input bit bpsk);
    for (int k = 0; k < len; k++) drive(i, q, bpsk);
  endtask

  function automatic int rs(input bit neg);
    if (neg) return -int'($urandom_range(1, 2048));
    return int'($urandom_range(0, 2047));
  endfunction

  // Monitor: pops the scoreboard whenever the DUT strobes vld
  bit       last_b  = 0;
  bit [1:0] last_dq = 2'b00;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("missed_vld", 0, 1);
        void'(sb.pop_front());
      end
      if (!rst_n) begin
        chk("rst_vld", int'(ifc.vld), 0);
        chk("rst_BPSK", int'(ifc.BPSK), 0);
        chk("rst_QPSK", int'(ifc.QPSK), 0);
        last_b  = 0;
        last_dq = 2'b00;
      end else if (ifc.vld === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_vld", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("vld_cycle", cyc, e.cyc);
          chk("BPSK", int'(ifc.BPSK), int'(e.b));
          chk("QPSK", int'(ifc.QPSK), int'(e.dq));
          last_b  = e.b;
          last_dq = e.dq;
        end
      end else begin
        chk("vld_low", int'(ifc.vld), 0);
        chk("BPSK_hold", int'(ifc.BPSK), int'(last_b));
        chk("QPSK_hold", int'(ifc.QPSK), int'(last_dq));
      end
    end
  end

  initial begin
    bit mode;
    int len;
    bit ni, nq;
    int bits[5];
    ifc.ADC_I = '0; ifc.ADC_Q = '0; ifc.is_bpsk = 1'b1;
    #5 rst_n = 1'b0;
    apply_reset(5);

    // Zero input never locks
    sym(0, 0, 200, 1'b1);

    // BPSK loopback 1,0,1,1,0
    bits = '{1, 0, 1, 1, 0};
    foreach (bits[k]) sym(bits[k] != 0 ? 1000 : -1000, 0, SPS, 1'b1);

    // QPSK constellation walk
    sym( 800, -800, SPS, 1'b0);
    sym(-800, -800, SPS, 1'b0);
    sym(-800,  800, SPS, 1'b0);
    sym( 800,  800, SPS, 1'b0);

    // Early boundary: one short symbol
    sym(-700, 0, SPS, 1'b1);
    sym( 700, 0, 28,  1'b1);
    sym(-700, 0, SPS, 1'b1);
    sym( 700, 0, SPS, 1'b1);

    // Late boundary: one long symbol
    sym(-700, 0, 36,  1'b1);
    sym( 700, 0, SPS, 1'b1);
    sym(-700, 0, SPS, 1'b1);

    // Zero after negative counts as a positive transition
    sym(-500, 0, SPS, 1'b1);
    sym(   0, 0, SPS, 1'b1);
    sym(-500, 0, SPS, 1'b1);

    // Reset mid-symbol, then re-lock
    sym(600, 0, 10, 1'b1);
    apply_reset(3);
    sym(600, 0, SPS, 1'b1);
    sym(-600, 0, SPS, 1'b1);
    sym(600, 0, SPS, 1'b1);

    // Randomized symbols with timing jitter and mode changes
    mode = 1'b1;
    for (int s = 0; s < 300; s++) begin
      if (s % 25 == 0) mode = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 44)) : SPS;
      ni  = 1'($urandom_range(0, 1));
      nq  = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        if (mode) drive(rs(ni), int'($urandom_range(0, 4095)) - 2048, 1'b1);
        else      drive(rs(ni), rs(nq), 1'b0);
      end
      if (s == 150) apply_reset(3);
    end

    sym(0, 0, 4, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/psk_rx_demod.md
Name:
psk_rx_demod

Overview:
- Baseband BPSK/QPSK receiver.
- Takes signed complex samples (I/Q) at one sample per clock and recovers symbol timing from zero crossings.
- Integrates and dumps each symbol, then issues hard bit decisions with a one-cycle valid strobe.
- Sits after the ADC interface and takes the transmitter's I/Q directly in loopback.

Parameters:
- DW, 12, sample width (signed two's complement).
- SPS, 32, samples (clocks) per symbol; power of two, minimum 8.

Ports:
- clk_16M384  input  1  sample clock, one I/Q sample per rising edge.
- rst_n_16M384  input  1  asynchronous, active-low reset.
- ADC_I  input  DW  in-phase sample, signed.
- ADC_Q  input  DW  quadrature sample, signed.
- is_bpsk  input  1  1 = BPSK mode, 0 = QPSK mode.
- BPSK  output  1  BPSK bit decision.
- QPSK  output  2  QPSK dibit decision: [1] from I, [0] from Q.
- vld  output  1  one-cycle strobe; decisions are new this cycle.

Behaviour:
- Reset (asynchronous, rst_n_16M384 low):
  - cnt=0, accI=accQ=0, prev signs=0, locked=0.
  - BPSK=0, QPSK=2'b00, vld=0.
- Sign convention: sign(x) = MSB; zero counts as positive.
- Accumulators: accI and accQ are signed, DW+log2(SPS) bits (17 at default). No saturation is needed.
- Phase counter: cnt runs 0..SPS-1 and wraps.
- Transition detect (combinational):
  - t = (sign(ADC_I) != prevI) OR (!is_bpsk AND sign(ADC_Q) != prevQ).
  - prevI/prevQ are updated every cycle with the current signs.
- Per cycle, evaluated in priority order:
  1. t=1 and locked=0:
     - locked<=1, cnt<=1, acc<=sample, no output.
  2. t=1, locked=1, cnt>=SPS/2 (early boundary):
     - Dump: decide on (acc + sample excluded), i.e. acc as held.
     - vld<=1; then cnt<=1, acc<=sample.
  3. t=1, locked=1, 1<=cnt<SPS/2 (late boundary):
     - acc<=sample, cnt<=1, no output.
  4. Otherwise with cnt==SPS-1 and locked=1 (nominal dump):
     - Decide on accI+ADC_I and accQ+ADC_Q.
     - vld<=1, acc<=0, cnt<=0.
  5. Otherwise:
     - acc<=acc+sample, cnt<=cnt+1.
     - If locked=0, acc is held at 0 and cnt at 0.
- t=1 at cnt==0 is aligned: handle it as case 5 (accumulate, cnt<=1). Case 3 therefore excludes cnt==0.
- Decision mapping:
  - BPSK = 1 if decided I sum >= 0, else 0.
  - QPSK[1] = (I sum >= 0); QPSK[0] = (Q sum >= 0).
  - BPSK and QPSK are both updated at every dump, regardless of mode.
- Output timing:
  - Outputs are registered and hold until the next dump.
  - vld is high for exactly one clock per dump.
  - Latency: outputs and vld are high the clock after the symbol's last sample.
- No output before lock: all-zero or constant-sign input never sets locked, so vld stays 0.
- Mode change: is_bpsk takes effect in the same cycle's transition detection; it does not reset state.
- Reset mid-symbol: all state cleared immediately; re-lock requires a new transition.

Test Plan:
- Reset: hold rst_n_16M384=0 with arbitrary inputs; then release with I=Q=0 for 200 clocks. Required: BPSK=0, QPSK=00, vld=0 throughout.
- BPSK loopback:
  - Stimulus: is_bpsk=1; I = +1000/-1000 per bit for pattern 1,0,1,1,0, SPS=32 samples each; Q=0.
  - Required: after lock at the first crossing, vld pulses every 32 clocks.
  - Required: BPSK sequence matches the bits transmitted after the lock symbol, with 1-clock latency after each symbol end.
- QPSK:
  - Stimulus: is_bpsk=0; (I,Q) = (+800,-800),(-800,-800),(-800,+800),(+800,+800), 32 samples each.
  - Required: QPSK = 10,00,01,11 after lock.
- Early boundary: lock, then make one symbol only 28 samples long. Required: vld fires at the crossing (cnt=28 >= 16) and following symbols stay aligned, with vld 32 clocks apart.
- Late boundary: make one symbol 36 samples long. Required:
  - Nominal dump at cnt=31.
  - The crossing 4 clocks later restarts cnt=1 without an extra vld.
  - Next vld occurs 32 clocks after that crossing.
- Zero/sign edge: an I symbol of all zeros after a -500 symbol. Required: counts as a transition; BPSK=1 for that symbol.
